// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches from a variable-latency
// instruction memory, decodes register/opcode fields and retires instructions.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            branch,
  input  logic            jump,
  input  logic            zero,
  input  logic [XLEN-1:0] immExt,
  output logic            instrValid,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      f3,
  output logic [6:0]      f7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic [31:0]     retired,
  output logic            misalignErr,
  output logic [1:0]      dbgState
);

  // Memory handshake: imem_req is the valid and is held with a stable
  // imem_addr until a cycle with imem_ready=1, which is the response; that
  // cycle completes the transfer. imem_ready is ignored when no request is up.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, VALID = 2'd2, HALT = 2'd3} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t          state;
  logic            pcSrc;
  logic [XLEN-1:0] pcNext;

  assign pcSrc     = jump | (branch & zero);
  assign pcPlus4   = pc + XLEN'(4);
  assign pcNext    = pcSrc ? (pc + immExt) : pcPlus4;
  assign imem_addr = pc;
  assign dbgState  = state;

  assign op  = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP;
      instrValid  <= 1'b0;
      imem_req    <= 1'b0;
      retired     <= 32'd0;
      misalignErr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= WAIT;
          imem_req <= 1'b1;
        end
        WAIT: begin
          if (imem_ready) begin
            instr      <= imem_rdata;
            instrValid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= VALID;
          end
        end
        VALID: begin
          // A stalled instruction ignores branch/jump/zero until it advances.
          if (!stall) begin
            instrValid <= 1'b0;
            if (pcNext[1:0] == 2'b00) begin
              pc       <= pcNext;
              retired  <= retired + 32'd1;
              imem_req <= 1'b1;
              state    <= WAIT;
            end else begin
              misalignErr <= 1'b1;
              state       <= HALT;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state      <= IDLE;
          imem_req   <= 1'b0;
          instrValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a phase-level reference model checked every
// cycle, plus literal expectations for the key fetch/branch/trap scenarios.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD = 32'h00A5_8533;
  localparam int PH_START = 0, PH_FETCH = 1, PH_HOLD = 2, PH_HALT = 3;

  logic        clk, reset;
  logic        imem_ready, stall, branch, jump, zero;
  logic [31:0] imem_rdata, immExt;

  logic        imem_req, instrValid, misalignErr;
  logic [31:0] imem_addr, instr, pc, pcPlus4, retired;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  dbgState;

  logic        d2Req, d2Valid, d2Err;
  logic [31:0] d2Addr, d2Instr, d2Pc, d2Pc4, d2Retired;
  logic [6:0]  d2Op, d2F7;
  logic [2:0]  d2F3;
  logic [4:0]  d2Rd, d2Rs1, d2Rs2;
  logic [1:0]  d2State;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch(branch), .jump(jump), .zero(zero), .immExt(immExt),
    .instrValid(instrValid), .instr(instr), .op(op), .f3(f3), .f7(f7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .pc(pc), .pcPlus4(pcPlus4),
    .retired(retired), .misalignErr(misalignErr), .dbgState(dbgState)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .imem_req(d2Req), .imem_addr(d2Addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch(branch), .jump(jump), .zero(zero), .immExt(immExt),
    .instrValid(d2Valid), .instr(d2Instr), .op(d2Op), .f3(d2F3), .f7(d2F7),
    .rd(d2Rd), .rs1(d2Rs1), .rs2(d2Rs2), .pc(d2Pc), .pcPlus4(d2Pc4),
    .retired(d2Retired), .misalignErr(d2Err), .dbgState(d2State)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  bit chkEn   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: program-order view of the fetch stage
  int          mdlPhase;
  logic [31:0] mdlPc, mdlInstr, mdlRetired;
  logic        mdlErr;

  always @(posedge clk) begin
    logic [63:0] sum;
    if (reset) begin
      mdlPhase = PH_START; mdlPc = 32'h0; mdlInstr = NOP;
      mdlRetired = 0; mdlErr = 1'b0;
    end else if (mdlPhase == PH_START) begin
      mdlPhase = PH_FETCH;
    end else if (mdlPhase == PH_FETCH) begin
      if (imem_ready) begin
        mdlInstr = imem_rdata;
        mdlPhase = PH_HOLD;
      end
    end else if (mdlPhase == PH_HOLD && !stall) begin
      sum = {32'b0, mdlPc} + ((jump || (branch && zero)) ? {32'b0, immExt} : 64'd4);
      if (sum % 4 == 0) begin
        mdlPc = sum[31:0];
        mdlRetired = mdlRetired + 1;
        mdlPhase = PH_FETCH;
      end else begin
        mdlErr = 1'b1;
        mdlPhase = PH_HALT;
      end
    end
  end

  // per-cycle compare
  always @(posedge clk) begin
    #1;
    if (chkEn) begin
      chk("imem_req",    imem_req,    (mdlPhase == PH_FETCH));
      chk("instrValid",  instrValid,  (mdlPhase == PH_HOLD));
      chk("imem_addr",   imem_addr,   mdlPc);
      chk("pc",          pc,          mdlPc);
      chk("pcPlus4",     pcPlus4,     mdlPc + 32'd4);
      chk("instr",       instr,       mdlInstr);
      chk("op",          op,          mdlInstr[6:0]);
      chk("f3",          f3,          mdlInstr[14:12]);
      chk("f7",          f7,          mdlInstr[31:25]);
      chk("rd",          rd,          mdlInstr[11:7]);
      chk("rs1",         rs1,         mdlInstr[19:15]);
      chk("rs2",         rs2,         mdlInstr[24:20]);
      chk("retired",     retired,     mdlRetired);
      chk("misalignErr", misalignErr, mdlErr);
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hold;
    int n = 0;
    while (mdlPhase != PH_HOLD && n < 20) begin
      tick();
      n++;
    end
    chk("wait_hold_instrValid", instrValid, 1);
  endtask

  task automatic advance(input logic br, input logic jp, input logic z,
                         input logic [31:0] imm, input logic [31:0] expAddr, input string name);
    wait_hold();
    branch = br; jump = jp; zero = z; immExt = imm;
    tick();
    branch = 0; jump = 0; zero = 0; immExt = 0;
    chk({name, "_req"}, imem_req, 1);
    chk({name, "_addr"}, imem_addr, expAddr);
  endtask

  logic [31:0] addrs[$];
  logic [31:0] addrs2[$];

  initial begin
    reset = 1; imem_ready = 0; imem_rdata = NOP; stall = 0;
    branch = 0; jump = 0; zero = 0; immExt = 0;
    tick();
    chkEn = 1;
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instrValid, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_retired", retired, 0);
    chk("rst_pc2", d2Pc, 32'hFFFF_FFFC);
    reset = 0;

    // zero-wait memory, NOPs everywhere
    imem_ready = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (imem_req) addrs.push_back(imem_addr);
      if (d2Req) addrs2.push_back(d2Addr);
    end
    imem_ready = 0;
    chk("zw_count", addrs.size(), 5);
    for (int i = 0; i < 4 && i < addrs.size(); i++) begin
      chk("zw_addr", addrs[i], 32'(4 * i));
    end
    chk("zw_retired", retired, 4);
    chk("zw_mdl_retired", mdlRetired, 4);
    chk("wrap_count", addrs2.size(), 5);
    if (addrs2.size() >= 2) begin
      chk("wrap_addr0", addrs2[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", addrs2[1], 32'h0);
    end
    chk("wrap_retired", d2Retired, 4);

    // 3-cycle latency at pc 0x10, then decode of ADD
    tick();
    chk("lat_req1", imem_req, 1); chk("lat_addr1", imem_addr, 32'h10); chk("lat_valid1", instrValid, 0);
    tick();
    chk("lat_req2", imem_req, 1); chk("lat_addr2", imem_addr, 32'h10); chk("lat_valid2", instrValid, 0);
    imem_ready = 1; imem_rdata = ADD;
    tick();
    imem_ready = 0;
    chk("lat_valid3", instrValid, 1); chk("lat_req3", imem_req, 0);
    chk("dec_op", op, 7'h33); chk("dec_f3", f3, 0); chk("dec_f7", f7, 0);
    chk("dec_rd", rd, 10); chk("dec_rs1", rs1, 11); chk("dec_rs2", rs2, 10);
    chk("mdl_instr", mdlInstr, ADD);

    // control-flow from pc 0x100
    imem_ready = 1; imem_rdata = NOP;
    advance(0, 1, 0, 32'h0000_00F0, 32'h100, "jmp_to_100");
    advance(1, 0, 1, 32'hFFFF_FFF8, 32'hF8,  "br_taken");
    advance(0, 1, 0, 32'h0000_0008, 32'h100, "back_100a");
    advance(1, 0, 0, 32'hFFFF_FFF8, 32'h104, "br_not_taken");
    advance(0, 1, 0, 32'hFFFF_FFFC, 32'h100, "back_100b");
    advance(0, 1, 0, 32'h0000_0020, 32'h120, "jmp_fwd");
    chk("cf_retired", retired, 10);

    // stall with toggling control inputs
    wait_hold();
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      branch = i[0]; zero = ~i[0]; jump = i[1]; immExt = 32'h0000_0006;
      tick();
      chk("stall_pc", pc, 32'h120);
      chk("stall_instr", instr, NOP);
      chk("stall_retired", retired, 10);
      chk("stall_valid", instrValid, 1);
    end
    stall = 0; branch = 1; zero = 1; jump = 0; immExt = 32'h40;
    tick();
    branch = 0; zero = 0; immExt = 0;
    chk("stall_adv_addr", imem_addr, 32'h160);
    chk("stall_adv_retired", retired, 11);

    // misaligned jump traps and halts
    wait_hold();
    jump = 1; immExt = 32'h6;
    tick();
    jump = 0; immExt = 0;
    chk("mis_err", misalignErr, 1);
    chk("mis_pc", pc, 32'h160);
    chk("mis_retired", retired, 11);
    for (int i = 0; i < 10; i++) begin
      imem_ready = i[0];
      tick();
      chk("halt_req", imem_req, 0);
      chk("halt_valid", instrValid, 0);
    end
    reset = 1; imem_ready = 0;
    tick();
    reset = 0;
    chk("rr_pc", pc, 32'h0); chk("rr_err", misalignErr, 0); chk("rr_req", imem_req, 0);
    tick();
    chk("rr_fetch_req", imem_req, 1); chk("rr_fetch_addr", imem_addr, 32'h0);
    imem_ready = 1;
    tick();
    imem_ready = 0;
    chk("rr_resume_valid", instrValid, 1);

    // reset mid-WAIT with a late response
    tick();
    chk("mw_req", imem_req, 1); chk("mw_addr", imem_addr, 32'h4);
    tick();
    reset = 1; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 0;
    chk("mw_rst_req", imem_req, 0); chk("mw_rst_instr", instr, NOP);
    chk("mw_rst_pc", pc, 32'h0); chk("mw_rst_state", dbgState, 0);
    tick();
    chk("mw_idle_req", imem_req, 1); chk("mw_idle_valid", instrValid, 0);
    chk("mw_idle_instr", instr, NOP);
    imem_ready = 0; imem_rdata = NOP;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V processor, directly upstream of the control unit `UC` and the datapath. Holds the program counter, fetches words from a variable-latency instruction memory, and presents the current instruction split into `op`/`f3`/`f7` and register fields. It advances the PC with the `branch`/`jump` signals produced by `UC` and the ALU `zero` flag. It also keeps a retired-instruction counter and traps misaligned control-flow targets.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (must be word-aligned)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  XLEN  fetch address, equals `pc`
- `imem_ready`  in  1  memory response valid, `imem_rdata` meaningful this cycle
- `imem_rdata`  in  32  fetched instruction word
- `stall`  in  1  downstream not ready; holds the current instruction
- `branch`  in  1  from UC
- `jump`  in  1  from UC
- `zero`  in  1  from ALU
- `immExt`  in  XLEN  sign-extended immediate from the extender
- `instrValid`  out  1  `instr` and fields are valid for execution
- `instr`  out  32  held instruction word
- `op`  out  7  `instr[6:0]`
- `f3`  out  3  `instr[14:12]`
- `f7`  out  7  `instr[31:25]`
- `rd`/`rs1`/`rs2`  out  5 each  `instr[11:7]` / `[19:15]` / `[24:20]`
- `pc`  out  XLEN  address of the current instruction
- `pcPlus4`  out  XLEN  `pc + 4`
- `retired`  out  32  count of instructions that have advanced
- `misalignErr`  out  1  sticky trap flag

## Operation
- States: IDLE, WAIT, VALID, HALT.
- IDLE: `imem_req`=0. Next state is unconditionally WAIT.
- WAIT: `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ready`. On `imem_ready`=1, `instr` <= `imem_rdata` and the FSM goes to VALID. Otherwise it stays in WAIT.
- VALID: `instrValid`=1 and `imem_req`=0.
  - If `stall`=1: hold everything. `branch`/`jump`/`zero` are ignored.
  - If `stall`=0 (advance): `pcSrc` = `jump | (branch & zero)`; `pcNext` = `pcSrc` ? `pc + immExt` : `pc + 4`.
  - Advance with `pcNext[1:0]`==0: `pc` <= `pcNext`, `retired` <= `retired + 1`, go to WAIT.
  - Advance with `pcNext[1:0]`!=0: `pc` unchanged, `retired` unchanged, `misalignErr` <= 1, go to HALT.
- HALT: `imem_req`=0 and `instrValid`=0. Only `reset` exits HALT.
- `imem_ready` is ignored in every state except WAIT.
- Arithmetic:
  - All PC sums are modulo 2^XLEN; `pc + 4` from 32'hFFFF_FFFC wraps to 0 with no flag.
  - `immExt` is treated as two's complement, so backward branches wrap naturally.
  - `retired` wraps from 32'hFFFF_FFFF to 0.
- Field outputs are combinational slices of `instr`. They are valid only while `instrValid`=1 and otherwise hold the last fetched word.

## Timing
- Reset values on the cycle after `reset` is sampled high: state IDLE, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `instrValid`=0, `imem_req`=0, `retired`=0, `misalignErr`=0.
- A reset asserted in any state, including mid-WAIT or HALT, wins over all other inputs. Any outstanding memory response is dropped; the memory must abandon the request on the same reset.
- First `imem_req` rises 1 cycle after reset deasserts (IDLE->WAIT).
- Fetch latency: if `imem_ready` is sampled in WAIT on edge N, `instrValid`=1 from edge N onward.
- Minimum 2 cycles per instruction (WAIT + VALID) with zero-wait memory, i.e. `imem_ready`=1 in the first WAIT cycle.
- `pc` changes only on an advancing VALID edge. `imem_addr` is therefore stable for the full WAIT period.
- `stall` is sampled only in VALID. A stall lasting k cycles extends VALID by k cycles.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0013 at every address -> `imem_addr` sequence 0,4,8,C on consecutive WAIT cycles; `retired`=4 after 8 cycles.
- Memory with 3-cycle latency -> `imem_req` high for 3 cycles with `imem_addr` stable; `instrValid` rises the cycle after `imem_ready`; fields decode 32'h00A58533 as `op`=7'h33, `f3`=0, `f7`=0, `rd`=10, `rs1`=11, `rs2`=10.
- Advance at `pc`=32'h100:
  - `branch`=1, `zero`=1, `immExt`=32'hFFFF_FFF8 -> next `imem_addr`=32'hF8.
  - `branch`=1, `zero`=0 -> `imem_addr`=32'h104.
  - `jump`=1, `immExt`=32'h20 -> `imem_addr`=32'h120.
- `stall`=1 for 5 cycles in VALID while `branch`/`zero` toggle -> `pc`, `instr` and `retired` unchanged; the advance uses the values present on the first `stall`=0 cycle.
- Advance with `jump`=1, `immExt`=32'h6 -> `misalignErr`=1, HALT, `imem_req` stays 0 for 10 cycles. Then `reset` -> `pc`=`RESET_PC`, `misalignErr`=0, fetch resumes.
- `RESET_PC`=32'hFFFF_FFFC with a NOP advance -> next `imem_addr`=0. Separately, `reset` asserted mid-WAIT with a late `imem_ready` -> the response is ignored and the state is IDLE.
